divisor_secuencial: RTL and testbench
=====================================

Name: divisor_secuencial

Overview:
- Sequential signed (two's-complement) divider.
- Inverse of the team's Booth multiplier: it takes a 2N-bit product-width dividend and an N-bit divisor, and returns an N-bit quotient and an N-bit remainder.
- Same start/fin handshake style as the multiplier, so the two can share a control bench and be chained (multiply, then divide back).
- Internally it uses a restoring unsigned core on operand magnitudes, followed by sign correction and a range check.

Parameters:
- N, default 3: divisor, quotient and remainder width. The dividend width is 2N.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- Dividendo  input  2N  signed dividend.
- Divisor  input  N  signed divisor.
- cociente  output  N  signed quotient, truncated toward zero.
- resto  output  N  signed remainder; sign follows the dividend.
- error  output  1  result invalid (divide by zero or quotient overflow).
- fin  output  1  one-cycle done pulse.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - cociente, resto, error, fin and all internal registers go to 0.
  - Reset mid-operation aborts the division; no fin is produced.
- States: IDLE, CARGA, ITERA, AJUSTE, FIN.
- IDLE:
  - On an edge with start=1: capture Dividendo and Divisor, go to CARGA.
  - Input changes after this edge are ignored.
- CARGA:
  - Load M = |Divisor| (N bits), Q = |Dividendo| (2N bits), A = 0 (N+1 bits).
  - Record sign_q = sign(Dividendo) XOR sign(Divisor) and sign_r = sign(Dividendo).
  - Clear the iteration counter.
  - If Divisor == 0: go directly to FIN with cociente=0, resto=0, error=1.
  - Otherwise go to ITERA.
- ITERA, one restoring step per cycle, 2N cycles total:
  - Shift {A,Q} left by 1.
  - If A - M >= 0: A = A - M, Q[0] = 1. Otherwise A is unchanged and Q[0] = 0.
  - Increment the counter. After the 2N-th step, go to AJUSTE.
- AJUSTE:
  - Magnitudes: Qmag = Q, Rmag = A[N-1:0]. Rmag < |Divisor| always fits.
  - Overflow conditions:
    - sign_q=0 and Qmag > 2^(N-1)-1, or
    - sign_q=1 and Qmag > 2^(N-1).
  - No overflow: cociente = sign_q ? -Qmag : Qmag; resto = sign_r ? -Rmag : Rmag; error = 0.
  - Overflow: cociente = 0, resto = 0, error = 1.
  - Go to FIN.
- FIN:
  - fin = 1 for exactly this cycle; next state IDLE unconditionally.
  - start during FIN is ignored. If start is still high in IDLE, a new operation begins on that edge.
- Latency, counting the edge that samples start as edge 1:
  - Normal operation: fin high after edge 2N+3 (9 for N=3).
  - Divide by zero: fin high after edge 2.
- Output holding:
  - cociente, resto and error are registered.
  - They hold their value from AJUSTE/CARGA until overwritten by the next completed operation or by reset.
  - They are stable while fin=1 and afterwards.
- start in CARGA, ITERA or AJUSTE: ignored, no restart.
- Negation of the most negative value is computed in a width one bit larger than the operand, so -2^(2N-1) dividends and -2^(N-1) divisors are handled.

Optional Feature:
- Macro: DIV_SATURA_EN.
- Defined: on quotient overflow, error=1 and the quotient saturates.
  - cociente = 2^(N-1)-1 when sign_q=0; cociente = -2^(N-1) when sign_q=1.
  - resto = 0.
  - Divide by zero: cociente saturates by the sign of Dividendo (positive or zero gives max, negative gives min), resto = 0.
- Not defined: the zeroed outputs described in Behaviour.
- Latency is identical either way.

Test Plan (N=3):
- Dividendo=6'b000111 (7), Divisor=3'b011 (3), start for 1 cycle -> after edge 9: cociente=3'b010, resto=3'b001, error=0, fin high exactly one cycle.
- Dividendo=-7 (6'b111001), Divisor=2 -> cociente=3'b101 (-3), resto=3'b111 (-1), error=0. Then 7 / -2 -> cociente=3'b101, resto=3'b001.
- Range edges:
  - -8 / 2 -> cociente=3'b100, resto=0, error=0.
  - 8 / 2 -> error=1 with cociente=0 (3'b011 with DIV_SATURA_EN).
  - -32 / -4 -> error=1.
- Divisor=0, Dividendo=5 -> fin after edge 2, error=1, cociente=0, resto=0 (3'b011 with DIV_SATURA_EN).
- Assert reset mid-ITERA (edge 4) -> outputs 0 immediately, no fin. A new start of 6/3 then gives cociente=2, resto=0 after 9 edges.
- start held high continuously with 7/3 -> back-to-back results, one fin every 10 cycles. Toggling inputs while busy leaves the current result unchanged.

Source files
------------

// File: rtl/divisor_secuencial.sv
// divisor_secuencial: sequential signed 2N/N restoring divider with start/fin handshake.
// Define DIV_SATURA_EN to saturate the quotient on overflow or divide by zero instead of zeroing it.
module divisor_secuencial #(
    parameter int N = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic signed [2*N-1:0] Dividendo,
    input  logic signed [N-1:0]   Divisor,
    output logic signed [N-1:0]   cociente,
    output logic signed [N-1:0]   resto,
    output logic                  error,
    output logic                  fin
);
    localparam int CW = $clog2(2*N+1);
    localparam logic [2*N-1:0] LIM_POS = (2*N)'(2**(N-1)-1);
    localparam logic [2*N-1:0] LIM_NEG = (2*N)'(2**(N-1));
    localparam logic [N-1:0] MAX_Q = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_Q = {1'b1, {(N-1){1'b0}}};
    typedef enum logic [2:0] {IDLE, CARGA, ITERA, AJUSTE, FIN} estado_t;
    estado_t        estado_q;
    logic [2*N-1:0] dvd_q, q_q;
    logic [N-1:0]   dvs_q, m_q, coc_q, res_q;
    logic [N:0]     a_q;
    logic [CW-1:0]  cnt_q;
    logic           neg_c_q, neg_r_q, err_q, fin_q;
    logic [2*N-1:0] dvd_abs, q_d;
    logic [N-1:0]   dvs_abs, q_sgn, r_sgn, coc_ovf, coc_dz;
    logic [N+1:0]   a_sub;
    logic [N:0]     a_d;
    logic           ge, ovf;
    always_comb begin
        // Negate one bit wider so the most negative operand yields its true magnitude
        dvd_abs = dvd_q[2*N-1] ? (2*N)'(-{1'b1, dvd_q}) : dvd_q;
        dvs_abs = dvs_q[N-1] ? N'(-{1'b1, dvs_q}) : dvs_q;
        a_sub   = {a_q, q_q[2*N-1]} - {2'b00, m_q};
        ge      = ~a_sub[N+1];
        a_d     = ge ? a_sub[N:0] : {a_q[N-1:0], q_q[2*N-1]};
        q_d     = {q_q[2*N-2:0], ge};
        ovf     = neg_c_q ? (q_q > LIM_NEG) : (q_q > LIM_POS);
        q_sgn   = neg_c_q ? -q_q[N-1:0] : q_q[N-1:0];
        r_sgn   = neg_r_q ? -a_q[N-1:0] : a_q[N-1:0];
`ifdef DIV_SATURA_EN
        coc_ovf = neg_c_q ? MIN_Q : MAX_Q;
        coc_dz  = dvd_q[2*N-1] ? MIN_Q : MAX_Q;
`else
        coc_ovf = '0;
        coc_dz  = MAX_Q & MIN_Q;
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            m_q      <= '0;
            q_q      <= '0;
            a_q      <= '0;
            cnt_q    <= '0;
            neg_c_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            coc_q    <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (estado_q)
                IDLE: if (start) begin
                    dvd_q    <= Dividendo;
                    dvs_q    <= Divisor;
                    estado_q <= CARGA;
                end
                CARGA: begin
                    m_q     <= dvs_abs;
                    q_q     <= dvd_abs;
                    a_q     <= '0;
                    neg_c_q <= dvd_q[2*N-1] ^ dvs_q[N-1];
                    neg_r_q <= dvd_q[2*N-1];
                    cnt_q   <= '0;
                    if (dvs_q == '0) begin
                        coc_q    <= coc_dz;
                        res_q    <= '0;
                        err_q    <= 1'b1;
                        fin_q    <= 1'b1;
                        estado_q <= FIN;
                    end else begin
                        estado_q <= ITERA;
                    end
                end
                ITERA: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(2*N-1)) estado_q <= AJUSTE;
                end
                AJUSTE: begin
                    coc_q    <= ovf ? coc_ovf : q_sgn;
                    res_q    <= ovf ? '0 : r_sgn;
                    err_q    <= ovf;
                    fin_q    <= 1'b1;
                    estado_q <= FIN;
                end
                FIN:     estado_q <= IDLE;
                default: estado_q <= IDLE;
            endcase
        end
    end
    assign cociente = coc_q;
    assign resto    = res_q;
    assign error    = err_q;
    assign fin      = fin_q;
endmodule

// File: tb/tb_divisor_secuencial.sv
// tb_divisor_secuencial: directed checks of the sequential signed divider (N=3).
module tb_divisor_secuencial;
    localparam int N = 3;
`ifdef DIV_SATURA_EN
    localparam int OVP = 3;
    localparam int OVN = 4;
`else
    localparam int OVP = 0;
    localparam int OVN = 0;
`endif
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [2*N-1:0] dvd = '0;
    logic [N-1:0] dvs = '0;
    logic [N-1:0] coc, res;
    logic         err, fin;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    divisor_secuencial #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .Dividendo(dvd), .Divisor(dvs),
        .cociente(coc), .resto(res), .error(err), .fin(fin)
    );
    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic run(input string tag, input logic [2*N-1:0] a, input logic [N-1:0] b,
                       input int lat, input int ec, input int er, input int ee);
        int e;
        dvd = a;
        dvs = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dvd = ~a;
        dvs = ~b;
        e = 1;
        while (!fin && e < 40) begin
            @(posedge clk);
            #1 e++;
        end
        check({tag, " latency"}, e, lat);
        check({tag, " cociente"}, int'(coc), ec);
        check({tag, " resto"}, int'(res), er);
        check({tag, " error"}, int'(err), ee);
        @(posedge clk);
        #1 check({tag, " fin pulse"}, int'(fin), 0);
        check({tag, " hold"}, int'(coc), ec);
    endtask
    initial begin
        int nfin, next;
        @(posedge clk);
        @(posedge clk);
        #1 check("reset cociente", int'(coc), 0);
        check("reset resto", int'(res), 0);
        check("reset error", int'(err), 0);
        check("reset fin", int'(fin), 0);
        reset = 1'b0;
        run("7/3", 6'b000111, 3'b011, 9, 2, 1, 0);
        run("-7/2", 6'b111001, 3'b010, 9, 5, 7, 0);
        run("7/-2", 6'b000111, 3'b110, 9, 5, 1, 0);
        run("-8/2", 6'b111000, 3'b010, 9, 4, 0, 0);
        run("8/2", 6'b001000, 3'b010, 9, OVP, 0, 1);
        run("-32/-4", 6'b100000, 3'b100, 9, OVP, 0, 1);
        run("-20/-4", 6'b101100, 3'b100, 9, OVP, 0, 1);
        run("5/0", 6'b000101, 3'b000, 2, OVP, 0, 1);
        run("-5/0", 6'b111011, 3'b000, 2, OVN, 0, 1);
        run("-7/2 again", 6'b111001, 3'b010, 9, 5, 7, 0);
        dvd = 6'b000111;
        dvs = 3'b011;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("abort cociente", int'(coc), 0);
        check("abort resto", int'(res), 0);
        check("abort error", int'(err), 0);
        nfin = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1 if (fin) nfin++;
        end
        check("abort no fin", nfin, 0);
        run("6/3", 6'b000110, 3'b011, 9, 2, 0, 0);
        dvd = 6'b000111;
        dvs = 3'b011;
        start = 1'b1;
        nfin = 0;
        next = 9;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1 if (e % 10 == 2) begin
                dvd = 6'b100000;
                dvs = 3'b001;
            end
            if (e % 10 == 8) begin
                dvd = 6'b000111;
                dvs = 3'b011;
            end
            if (fin) begin
                nfin++;
                check("b2b fin edge", e, next);
                check("b2b cociente", int'(coc), 2);
                check("b2b resto", int'(res), 1);
                next += 10;
            end
        end
        start = 1'b0;
        check("b2b fin count", nfin, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
